output_argmax96: RTL and testbench

Downstream classification stage for the `top` inference engine. It captures each 3-wide FP16 result vector on the rising edge of `output_ready96` and buffers it in a small FIFO. Each buffered vector is then scanned sequentially, one element per cycle, to find the largest value. The winning index and its raw FP16 value are presented on a valid/ready interface, together with a running count of delivered rounds.

---
 rtl/output_argmax96.sv | 245 ++++++++++++++++++++++++
 tb/tb_output_argmax96.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_argmax96.sv
// output_argmax96
// Captures FP16 result vectors on the rising edge of output_ready96 and
// buffers them in a small circular FIFO. Each vector is then scanned one
// element per cycle for its maximum. The winning index and raw FP16 bits are
// offered on a valid/ready interface with a running delivered-round count.
// FP16 ordering uses a 16-bit unsigned key: -0 folds onto +0, NaN is the
// smallest value, and ties keep the lowest index.

module output_argmax96 #(
    parameter int NUM_OUTPUTS96 = 3,
    parameter int FIFO_DEPTH96  = 4,
    parameter int IDX_W96       = $clog2(NUM_OUTPUTS96)
) (
    input  logic                             clk96,
    input  logic                             rst_n96,
    input  logic                             output_ready96,
    input  logic [NUM_OUTPUTS96-1:0][15:0]   outtie96,
    input  logic                             class_ready96,
    output logic                             class_valid96,
    output logic [IDX_W96-1:0]               class_idx96,
    output logic [15:0]                      class_value96,
    output logic [$clog2(FIFO_DEPTH96):0]    fifo_count96,
    output logic                             overflow96,
    output logic [12:0]                      round_count96
);

    localparam int PTR_W = (FIFO_DEPTH96 > 1) ? $clog2(FIFO_DEPTH96) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH96) + 1;

    typedef logic [NUM_OUTPUTS96-1:0][15:0] vec_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_HOLD
    } state_t;

    // Map FP16 bits onto an unsigned key whose order matches numeric order.
    function automatic logic [15:0] f_key(input logic [15:0] x);
        logic [15:0] k;
        if ((x[14:10] == 5'h1F) && (x[9:0] != 10'd0)) begin
            k = 16'h0000;                     // NaN ranks below everything
        end else if (x == 16'h8000) begin
            k = 16'h8000;                     // -0 compares equal to +0
        end else if (!x[15]) begin
            k = {1'b1, x[14:0]};
        end else begin
            k = {1'b0, ~x[14:0]};
        end
        return k;
    endfunction

    // Edge detect and FIFO bookkeeping
    logic                 r_prev96;
    logic                 w_push;
    logic                 w_full;
    logic                 w_accept;
    logic                 w_pop;
    vec_t                 r_mem [FIFO_DEPTH96];
    vec_t                 w_head;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_overflow;

    // Control
    state_t               r_state;
    state_t               w_state_next;
    logic                 w_scan;
    logic                 w_done;
    logic                 w_xfer;

    // Scan datapath
    vec_t                 r_work;
    logic [15:0]          r_best_key;
    logic [15:0]          r_best_val;
    logic [IDX_W96-1:0]   r_best_idx;
    logic [IDX_W96-1:0]   r_i;
    logic [15:0]          w_elem;
    logic [15:0]          w_elem_key;
    logic                 w_better;
    logic                 w_last;
    logic [15:0]          w_win_key;
    logic [15:0]          w_win_val;
    logic [IDX_W96-1:0]   w_win_idx;

    // Result registers
    logic [IDX_W96-1:0]   r_class_idx;
    logic [15:0]          r_class_value;
    logic [12:0]          r_round_count;

    assign w_push   = output_ready96 & ~r_prev96;
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH96));
    // A full FIFO still takes the new vector when the head leaves on the same edge.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_head   = r_mem[r_rd_ptr];

    assign w_elem     = r_work[r_i];
    assign w_elem_key = f_key(w_elem);
    assign w_better   = (w_elem_key > r_best_key);
    assign w_last     = (r_i == IDX_W96'(NUM_OUTPUTS96 - 1));
    assign w_win_key  = w_better ? w_elem_key : r_best_key;
    assign w_win_val  = w_better ? w_elem     : r_best_val;
    assign w_win_idx  = w_better ? r_i        : r_best_idx;

    // Remember the previous strobe level so a long strobe pushes only once.
    always_ff @(posedge clk96) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked body
        // rather than appearing in the sensitivity list.
        if (!rst_n96) begin
            r_prev96 <= 1'b0;
        end else begin
            // NOTE: state is always assigned with <= so every register samples
            // the pre-edge values of its peers.
            r_prev96 <= output_ready96;
        end
    end

    // FIFO storage array; written only when a vector is accepted.
    always_ff @(posedge clk96) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // count define which entries are live, so stale data is never read.
        if (w_accept) begin
            r_mem[r_wr_ptr] <= outtie96;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk96) begin
        if (!rst_n96) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH96 - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH96 - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk96) begin
        if (!rst_n96) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_scan       = 1'b0;
        w_done       = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                w_scan = 1'b1;
                if (w_last) begin
                    w_done       = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (class_ready96) begin
                    w_xfer       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Scan datapath: load the head vector, then fold one element per cycle.
    always_ff @(posedge clk96) begin
        if (!rst_n96) begin
            r_work     <= '0;
            r_best_key <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_i        <= '0;
        end else if (w_pop) begin
            r_work     <= w_head;
            r_best_key <= f_key(w_head[0]);
            r_best_val <= w_head[0];
            r_best_idx <= '0;
            r_i        <= IDX_W96'(1);
        end else if (w_scan) begin
            r_best_key <= w_win_key;
            r_best_val <= w_win_val;
            r_best_idx <= w_win_idx;
            if (!w_last) begin
                r_i <= r_i + 1'b1;
            end
        end
    end

    // Result registers: written once per vector, held through backpressure.
    always_ff @(posedge clk96) begin
        if (!rst_n96) begin
            r_class_idx   <= '0;
            r_class_value <= '0;
            r_round_count <= '0;
        end else begin
            if (w_done) begin
                r_class_idx   <= w_win_idx;
                r_class_value <= w_win_val;
            end
            if (w_xfer) begin
                r_round_count <= r_round_count + 1'b1;
            end
        end
    end

    assign class_valid96 = (r_state == S_HOLD);
    assign class_idx96   = r_class_idx;
    assign class_value96 = r_class_value;
    assign fifo_count96  = r_count;
    assign overflow96    = r_overflow;
    assign round_count96 = r_round_count;

endmodule

// File: tb/tb_output_argmax96.sv
// tb_output_argmax96
// Scoreboard bench: the stimulus side pushes the expected argmax of every
// accepted vector, computed from real-valued FP16 decoding; a monitor pops
// and compares whenever the DUT presents a result.

module tb_output_argmax96;

    localparam int N = 3;
    localparam int D = 4;

    logic                 clk96 = 1'b0;
    logic                 rst_n96;
    logic                 output_ready96;
    logic [N-1:0][15:0]   outtie96;
    logic                 class_ready96;
    logic                 class_valid96;
    logic [1:0]           class_idx96;
    logic [15:0]          class_value96;
    logic [2:0]           fifo_count96;
    logic                 overflow96;
    logic [12:0]          round_count96;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   exp_rounds = 0;
    bit   rand_ready = 1'b0;

    output_argmax96 #(
        .NUM_OUTPUTS96 (N),
        .FIFO_DEPTH96  (D)
    ) dut (
        .clk96          (clk96),
        .rst_n96        (rst_n96),
        .output_ready96 (output_ready96),
        .outtie96       (outtie96),
        .class_ready96  (class_ready96),
        .class_valid96  (class_valid96),
        .class_idx96    (class_idx96),
        .class_value96  (class_value96),
        .fifo_count96   (fifo_count96),
        .overflow96     (overflow96),
        .round_count96  (round_count96)
    );

    initial forever #5 clk96 = ~clk96;

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic real pow2(input int n);
        real p = 1.0;
        if (n >= 0) begin
            for (int k = 0; k < n; k++) p = p * 2.0;
        end else begin
            for (int k = 0; k < -n; k++) p = p / 2.0;
        end
        return p;
    endfunction

    // Numeric value of an FP16 pattern; NaN ranks below -inf.
    function automatic real fp16_rank(input logic [15:0] x);
        int  e;
        int  m;
        real mag;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        if (e == 31) begin
            if (m != 0) return -1.0e300;
            return x[15] ? -1.0e200 : 1.0e200;
        end
        if (e == 0) mag = real'(m) * pow2(-24);
        else        mag = real'(m + 1024) * pow2(e - 25);
        return x[15] ? -mag : mag;
    endfunction

    // First index holding the numerically largest value.
    function automatic exp_t model(input logic [N-1:0][15:0] v);
        exp_t r;
        real  best;
        r.idx = 0;
        best  = fp16_rank(v[0]);
        for (int k = 1; k < N; k++) begin
            if (fp16_rank(v[k]) > best) begin
                best  = fp16_rank(v[k]);
                r.idx = k;
            end
        end
        r.val = v[r.idx];
        return r;
    endfunction

    task automatic strobe(input logic [N-1:0][15:0] v, input int width, input bit accept);
        @(negedge clk96);
        outtie96       = v;
        output_ready96 = 1'b1;
        if (accept) sb_q.push_back(model(v));
        repeat (width) @(negedge clk96);
        output_ready96 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (sb_q.size() != 0 && c < budget) begin
            @(posedge clk96);
            c++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sb_q.size());
        end
        repeat (2) @(posedge clk96);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk96);
        rst_n96        = 1'b0;
        output_ready96 = 1'b0;
        repeat (cycles) @(negedge clk96);
        sb_q.delete();
        exp_rounds = 0;
        rst_n96    = 1'b1;
    endtask

    function automatic logic [15:0] rand_fp16();
        logic [15:0] specials [8];
        specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                     16'h7E00, 16'hFE01, 16'h3C00, 16'hBC00};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    // Monitor: compare every presented result against the scoreboard head.
    initial forever begin
        exp_t e;
        @(negedge clk96);
        #1;
        if (class_valid96 === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got idx %0d value 0x%0h, expected no result",
                         class_idx96, class_value96);
            end else begin
                e = sb_q[0];
                check("result_idx", 32'(class_idx96), 32'(e.idx));
                check("result_value", 32'(class_value96), 32'(e.val));
                if (class_ready96 === 1'b1) begin
                    check("round_count_at_transfer", 32'(round_count96), 32'(exp_rounds % 8192));
                    exp_rounds++;
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // Random downstream backpressure while enabled.
    initial forever begin
        @(negedge clk96);
        if (rand_ready) class_ready96 = 1'($urandom_range(0, 1));
    end

    initial begin
        int lat;
        bit found;
        logic [N-1:0][15:0] v;
        logic [N-1:0][15:0] ovf_tab [6];

        rst_n96        = 1'b0;
        output_ready96 = 1'b0;
        outtie96       = '0;
        class_ready96  = 1'b0;

        // Reset held for three cycles with the strobe toggling.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk96);
            output_ready96 = ~output_ready96;
            outtie96       = {16'($urandom), 16'($urandom), 16'($urandom)};
            @(posedge clk96);
            #1;
            check("reset_valid", 32'(class_valid96), 0);
            check("reset_fifo_count", 32'(fifo_count96), 0);
            check("reset_idx", 32'(class_idx96), 0);
            check("reset_value", 32'(class_value96), 0);
            check("reset_overflow", 32'(overflow96), 0);
            check("reset_rounds", 32'(round_count96), 0);
        end
        @(negedge clk96);
        output_ready96 = 1'b0;
        rst_n96        = 1'b1;
        repeat (6) @(posedge clk96);
        #1;
        check("post_reset_no_capture_fifo", 32'(fifo_count96), 0);
        check("post_reset_no_capture_valid", 32'(class_valid96), 0);

        // Basic argmax and latency.
        @(negedge clk96);
        v              = {16'h3800, 16'h4000, 16'h3C00};
        outtie96       = v;
        output_ready96 = 1'b1;
        sb_q.push_back(model(v));
        lat   = 0;
        found = 1'b0;
        for (int c = 1; c <= 12 && !found; c++) begin
            @(posedge clk96);
            #1;
            if (class_valid96) begin
                found = 1'b1;
                lat   = c;
            end
            @(negedge clk96);
            output_ready96 = 1'b0;
        end
        check("valid_edges_after_capture", 32'(lat - 1), 3);
        check("basic_idx", 32'(class_idx96), 1);
        check("basic_value", 32'(class_value96), 32'h4000);
        class_ready96 = 1'b1;
        drain(50);
        check("basic_rounds", 32'(round_count96), 1);

        // Negatives, signed zeros, NaN and infinities.
        strobe({16'hB800, 16'hC000, 16'hBC00}, 1, 1'b1);
        strobe({16'h8000, 16'h0000, 16'h8000}, 1, 1'b1);
        strobe({16'h3C00, 16'h7C00, 16'h7E00}, 1, 1'b1);
        strobe({16'h7E01, 16'hFE00, 16'h7E00}, 1, 1'b1);
        drain(100);
        check("special_rounds", 32'(round_count96), 5);

        // A wide strobe captures exactly once.
        strobe({16'h0400, 16'h5000, 16'h4800}, 5, 1'b1);
        drain(50);
        check("wide_strobe_rounds", 32'(round_count96), 6);
        repeat (8) @(posedge clk96);
        #1;
        check("wide_strobe_no_extra_valid", 32'(class_valid96), 0);
        check("wide_strobe_fifo_empty", 32'(fifo_count96), 0);

        // Reset during a scan abandons the result.
        strobe({16'h1234, 16'h2345, 16'h3456}, 1, 1'b0);
        @(posedge clk96);
        do_reset(2);
        @(posedge clk96);
        #1;
        check("midscan_reset_fifo", 32'(fifo_count96), 0);
        check("midscan_reset_rounds", 32'(round_count96), 0);
        repeat (8) @(posedge clk96);
        #1;
        check("midscan_reset_no_valid", 32'(class_valid96), 0);

        // Backpressure and overflow.
        ovf_tab[0] = {16'h3800, 16'h3C00, 16'h4400};
        ovf_tab[1] = {16'h3800, 16'h4400, 16'h3C00};
        ovf_tab[2] = {16'h4400, 16'h3800, 16'h3C00};
        ovf_tab[3] = {16'hC000, 16'hBC00, 16'hC400};
        ovf_tab[4] = {16'h0000, 16'h7E00, 16'h7C00};
        ovf_tab[5] = {16'h0003, 16'h0002, 16'h0001};
        class_ready96 = 1'b0;
        for (int k = 0; k < 5; k++) strobe(ovf_tab[k], 1, 1'b1);
        #1;
        check("backpressure_fifo_full", 32'(fifo_count96), 4);
        check("backpressure_no_overflow_yet", 32'(overflow96), 0);
        strobe(ovf_tab[5], 1, 1'b0);
        #1;
        check("overflow_flag", 32'(overflow96), 1);
        check("overflow_fifo_count", 32'(fifo_count96), 4);
        check("overflow_valid_held", 32'(class_valid96), 1);
        class_ready96 = 1'b1;
        drain(200);
        check("overflow_rounds", 32'(round_count96), 5);
        check("overflow_sticky", 32'(overflow96), 1);

        // Randomised vectors with random backpressure.
        do_reset(2);
        rand_ready = 1'b1;
        for (int it = 0; it < 60; it++) begin
            int w = 0;
            while (sb_q.size() >= 4 && w < 1000) begin
                @(negedge clk96);
                w++;
            end
            if (w >= 1000) begin
                n_checks++;
                n_errors++;
                $display("FAIL random_space_timeout: %0d pending, expected fewer than 4", sb_q.size());
            end
            v = {rand_fp16(), rand_fp16(), rand_fp16()};
            strobe(v, $urandom_range(1, 3), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk96);
        end
        @(negedge clk96);
        rand_ready    = 1'b0;
        class_ready96 = 1'b1;
        drain(1000);
        check("random_rounds", 32'(round_count96), 32'(exp_rounds % 8192));
        check("random_no_overflow", 32'(overflow96), 0);
        check("random_fifo_empty", 32'(fifo_count96), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
